// File: rtl/ct_pkg.sv
// Shared definitions for the ct_mac_array block: FSM state encoding and
// the default datapath widths used as parameter defaults.
package ct_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int LEN_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ct_mac_lane.sv
// One channel of the MAC array: unsigned multiply, saturating or wrapping
// accumulate, accumulator register and a sticky saturation bit.
module ct_mac_lane
    import ct_pkg::*;
#(
    parameter int DATA_W = ct_pkg::DATA_W,
    parameter int ACC_W  = ct_pkg::ACC_W,
    parameter int SAT_EN = 1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              load,
    input  logic              beat,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] subject,
    output logic [ACC_W-1:0]  acc,
    output logic              sat
);

    // Zero padding that lifts the product to ACC_W+1 bits.
    localparam int PAD_W = ACC_W + 1 - 2 * DATA_W;

    logic [2*DATA_W-1:0] product;
    logic [ACC_W:0]      sum;

    // Full-width product and a sum one bit wider than the accumulator,
    // so the top bit is the overflow indication.
    always_comb begin
        // NOTE: every combinational output gets a value on every path, so no latch is inferred.
        product = {{DATA_W{1'b0}}, subject} * {{DATA_W{1'b0}}, weight};
        sum     = {1'b0, acc} + {{PAD_W{1'b0}}, product};
    end

    // Accumulator and sticky saturation bit; clear and run start both zero them.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
        if (clear || load) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (beat) begin
            if ((SAT_EN != 0) && sum[ACC_W]) begin
                acc <= '1;
                sat <= 1'b1;
            end else begin
                acc <= sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ct_mac_array.sv
// N_CH-channel multiply-accumulate array sharing one weight per beat.
// A run of len_in beats is accumulated, then the result is held until taken.
module ct_mac_array
    import ct_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = ct_pkg::DATA_W,
    parameter int ACC_W  = ct_pkg::ACC_W,
    parameter int LEN_W  = ct_pkg::LEN_W,
    parameter int SAT_EN = 1
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len_in,
    input  logic [DATA_W-1:0]      weight_in,
    input  logic [N_CH*DATA_W-1:0] subject_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_CH*ACC_W-1:0]  calc_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N_CH-1:0]        sat_flag,
    output logic                   busy
);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] count_next;
    logic             load;
    logic             beat;

    // count never exceeds len_q, so LEN_W bits cover the longest run.
    assign count_next = count + 1'b1;
    assign load       = (state == IDLE) && start;
    assign beat       = in_valid && in_ready;

    // Run control FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            len_q     <= '0;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len_in;
                        count <= '0;
                        busy  <= 1'b1;
                        if (len_in != '0) begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        count <= count_next;
                        if (count_next == len_q) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        ct_mac_lane #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .SAT_EN (SAT_EN)
        ) u_lane (
            .clk     (clk),
            .clear   (clear),
            .load    (load),
            .beat    (beat),
            .weight  (weight_in),
            .subject (subject_in[i*DATA_W +: DATA_W]),
            .acc     (calc_out[i*ACC_W +: ACC_W]),
            .sat     (sat_flag[i])
        );
    end

endmodule

// File: tb/tb_ct_mac_array.sv
// Bench for ct_mac_array: one saturating and one wrapping instance share
// the same stimulus; expected results come from a hand-filled vector table.
module tb_ct_mac_array;

    localparam int N_CH   = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int LEN_W  = 8;

    typedef struct {
        int                          len;
        logic [DATA_W-1:0]           weight;
        logic [N_CH-1:0][DATA_W-1:0] subj;
        logic [N_CH-1:0][ACC_W-1:0]  exp_sat;
        logic [N_CH-1:0]             exp_flags;
        logic [N_CH-1:0][ACC_W-1:0]  exp_wrap;
    } vec_t;

    typedef struct {
        logic [N_CH-1:0][ACC_W-1:0] calc_sat;
        logic [N_CH-1:0]            flags;
        logic [N_CH-1:0][ACC_W-1:0] calc_wrap;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   clear;
    logic                   start;
    logic [LEN_W-1:0]       len_in;
    logic [DATA_W-1:0]      weight_in;
    logic [N_CH*DATA_W-1:0] subject_in;
    logic                   in_valid;
    logic                   out_ready;

    logic                   in_ready,  in_ready_w;
    logic [N_CH*ACC_W-1:0]  calc_out,  calc_out_w;
    logic                   out_valid, out_valid_w;
    logic [N_CH-1:0]        sat_flag,  sat_flag_w;
    logic                   busy,      busy_w;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    ct_mac_array #(
        .N_CH(N_CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .SAT_EN(1)
    ) u_sat (
        .clk(clk), .clear(clear), .start(start), .len_in(len_in),
        .weight_in(weight_in), .subject_in(subject_in), .in_valid(in_valid),
        .in_ready(in_ready), .calc_out(calc_out), .out_valid(out_valid),
        .out_ready(out_ready), .sat_flag(sat_flag), .busy(busy)
    );

    ct_mac_array #(
        .N_CH(N_CH), .DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W), .SAT_EN(0)
    ) u_wrap (
        .clk(clk), .clear(clear), .start(start), .len_in(len_in),
        .weight_in(weight_in), .subject_in(subject_in), .in_valid(in_valid),
        .in_ready(in_ready_w), .calc_out(calc_out_w), .out_valid(out_valid_w),
        .out_ready(out_ready), .sat_flag(sat_flag_w), .busy(busy_w)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One complete run: start, beats (optionally gapped with start noise),
    // scoreboard compare on out_valid, hold in DONE, then release.
    task automatic run_vec(input vec_t v, input bit gaps, input int hold);
        exp_t e;
        int   beats;
        int   cyc;
        bit   ready_ok;
        e.calc_sat  = v.exp_sat;
        e.flags     = v.exp_flags;
        e.calc_wrap = v.exp_wrap;
        sb.push_back(e);

        start  = 1'b1;
        len_in = v.len[LEN_W-1:0];
        @(negedge clk);
        start  = 1'b0;
        len_in = LEN_W'($urandom);

        ready_ok = 1'b1;
        beats    = 0;
        cyc      = 0;
        while (beats < v.len && cyc < 1000) begin
            if (!in_ready || !in_ready_w || !busy || out_valid) ready_ok = 1'b0;
            if (gaps && cyc[0]) begin
                in_valid   = 1'b0;
                weight_in  = DATA_W'($urandom);
                subject_in = {$urandom, $urandom};
                start      = 1'b1;
                len_in     = LEN_W'($urandom);
            end else begin
                in_valid   = 1'b1;
                weight_in  = v.weight;
                subject_in = v.subj;
                start      = 1'b0;
            end
            @(negedge clk);
            if (in_valid) beats++;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (v.len != 0) check("in_ready_during_accum", 64'(ready_ok), 64'd1);
        check("out_valid_latency", {out_valid, out_valid_w}, 2'b11);

        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            check("out_valid_timeout", 64'(out_valid), 64'd1);
        end else begin
            check("calc_out_sat",  calc_out,   e.calc_sat);
            check("sat_flag_sat",  sat_flag,   e.flags);
            check("calc_out_wrap", calc_out_w, e.calc_wrap);
            check("sat_flag_wrap", sat_flag_w, '0);
        end

        for (int i = 0; i < hold; i++) begin
            start  = 1'b1;
            len_in = LEN_W'($urandom);
            @(negedge clk);
            check("hold_calc_out", calc_out, e.calc_sat);
            check("hold_out_valid", {out_valid, in_ready}, 2'b10);
        end

        // start together with out_ready must not begin a new run
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("release_to_idle", {out_valid, in_ready, busy, busy_w}, 4'b0000);
        @(negedge clk);
        check("stay_idle", {out_valid, in_ready, busy}, 3'b000);
    endtask

    initial begin
        // len, weight, subjects {ch3..ch0}, sat result, flags, wrap result
        vecs[0] = '{4,   8'd2,   {8'd4, 8'd3, 8'd2, 8'd1},
                    {16'd32, 16'd24, 16'd16, 16'd8}, 4'b0000,
                    {16'd32, 16'd24, 16'd16, 16'd8}};
        vecs[1] = '{2,   8'd255, {8'd255, 8'd255, 8'd255, 8'd255},
                    {16'd65535, 16'd65535, 16'd65535, 16'd65535}, 4'b1111,
                    {16'd64514, 16'd64514, 16'd64514, 16'd64514}};
        vecs[2] = '{0,   8'd7,   {8'd9, 8'd9, 8'd9, 8'd9},
                    {16'd0, 16'd0, 16'd0, 16'd0}, 4'b0000,
                    {16'd0, 16'd0, 16'd0, 16'd0}};
        vecs[3] = '{1,   8'd3,   {8'd255, 8'd100, 8'd10, 8'd0},
                    {16'd765, 16'd300, 16'd30, 16'd0}, 4'b0000,
                    {16'd765, 16'd300, 16'd30, 16'd0}};
        vecs[4] = '{2,   8'd255, {8'd128, 8'd0, 8'd1, 8'd255},
                    {16'd65280, 16'd0, 16'd510, 16'd65535}, 4'b0001,
                    {16'd65280, 16'd0, 16'd510, 16'd64514}};
        vecs[5] = '{255, 8'd1,   {8'd255, 8'd0, 8'd2, 8'd1},
                    {16'd65025, 16'd0, 16'd510, 16'd255}, 4'b0000,
                    {16'd65025, 16'd0, 16'd510, 16'd255}};
        vecs[6] = '{3,   8'd200, {8'd255, 8'd50, 8'd0, 8'd100},
                    {16'd65535, 16'd30000, 16'd0, 16'd60000}, 4'b1000,
                    {16'd21928, 16'd30000, 16'd0, 16'd60000}};

        clear      = 1'b1;
        start      = 1'b0;
        len_in     = '0;
        weight_in  = '0;
        subject_in = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b0;
        check("reset_calc_out", calc_out, '0);
        check("reset_flags", {sat_flag, sat_flag_w}, '0);
        check("reset_ctrl", {out_valid, in_ready, busy, out_valid_w, in_ready_w, busy_w}, '0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], 1'b0, (vecs[i].len == 0) ? 5 : 1);
        end

        // alternate idle cycles with start noise must give the same result
        run_vec(vecs[0], 1'b1, 2);

        // clear mid-run, asserted together with start, in_valid and out_ready
        start  = 1'b1;
        len_in = 8'd4;
        @(negedge clk);
        start      = 1'b0;
        in_valid   = 1'b1;
        weight_in  = 8'd255;
        subject_in = {8'd255, 8'd255, 8'd255, 8'd255};
        repeat (2) @(negedge clk);
        check("pre_clear_sat_flag", sat_flag, 4'b1111);
        clear     = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("clear_calc_out", {calc_out, calc_out_w}, '0);
        check("clear_flags", {sat_flag, sat_flag_w}, '0);
        check("clear_ctrl", {out_valid, in_ready, busy, out_valid_w, in_ready_w, busy_w}, '0);
        @(negedge clk);
        check("clear_stays_idle", {out_valid, in_ready, busy}, 3'b000);
        run_vec(vecs[0], 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
